// File: rtl/uart_rx_fifo_less_v2.sv
// UART receiver with a runtime bit period, optional parity, 1-2 stop bits and a valid/ready output.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of the last three line samples.
module uart_rx_fifo_less_v2 #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter bit PARITY_EN   = 1'b1,
  parameter bit PARITY_EVEN = 1'b1,
  parameter int DIV_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic [DIV_W-1:0]     div,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]           state;
  logic                 s1;
  logic                 s;
  logic                 s_q;
  logic [DIV_W-1:0]     per;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     target;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 at_target;
  logic                 b;
  logic                 commit;
  logic                 commit_ferr;

`ifdef UART_RX_MAJORITY_EN
  logic s_qq;

  always_ff @(posedge clk) begin
    if (!rst_n) s_qq <= 1'b1;
    else        s_qq <= s_q;
  end

  // s_q and s_qq hold the line at target-1 and target-2
  assign b = (s & s_q) | (s & s_qq) | (s_q & s_qq);
`else
  assign b = s;
`endif

  assign target      = (state == START) ? ((per >> 1) - DIV_W'(1)) : (per - DIV_W'(1));
  assign at_target   = (cnt == target);
  assign commit      = (state == STOP) && at_target && (bit_idx == 4'(STOP_BITS - 1));
  assign commit_ferr = ferr | ~b;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      s1      <= 1'b1;
      s       <= 1'b1;
      s_q     <= 1'b1;
      per     <= DIV_W'(8);
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      s1  <= din;
      s   <= s1;
      s_q <= s;
      cnt <= cnt + DIV_W'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s_q && !s) begin
            state <= START;
            per   <= (div < DIV_W'(8)) ? DIV_W'(8) : div;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        START: begin
          if (at_target) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= b ? IDLE : DATA;
          end
        end
        DATA: begin
          if (at_target) begin
            cnt   <= '0;
            shreg <= {b, shreg[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= PARITY_EN ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PAR: begin
          if (at_target) begin
            cnt     <= '0;
            bit_idx <= '0;
            perr    <= PARITY_EVEN ? (b != ^shreg) : (b != ~^shreg);
            state   <= STOP;
          end
        end
        STOP: begin
          if (at_target) begin
            cnt  <= '0;
            ferr <= commit_ferr;
            if (commit) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A commit coinciding with a handshake replaces the word being consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit && (!valid || ready)) begin
        data_out   <= shreg;
        parity_err <= perr;
        frame_err  <= commit_ferr;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (commit && valid && !ready) overrun <= 1'b1;
      else if (valid && ready)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_less_v2.sv
// Directed bench: table of whole frames plus hand-written glitch, break, overrun, divisor, reset and spike sequences.
module tb_uart_rx_fifo_less_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [15:0] div;
  logic        ready;
  logic [7:0]  data_out, data_out_o;
  logic        valid, valid_o;
  logic        parity_err, parity_err_o;
  logic        frame_err, frame_err_o;
  logic        overrun, overrun_o;
  logic        busy, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_less_v2 u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .div(div),
    .data_out(data_out), .valid(valid), .ready(ready),
    .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_fifo_less_v2 #(.PARITY_EVEN(1'b0)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din), .div(div),
    .data_out(data_out_o), .valid(valid_o), .ready(ready),
    .parity_err(parity_err_o), .frame_err(frame_err_o),
    .overrun(overrun_o), .busy(busy_o)
  );

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stp;
    int         div_v;
    int         per;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_pe_odd;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  // Pin cycle 0 is the start-bit fall; spike flips one pin cycle, len truncates the frame
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                            input int per, input int spike, input int len);
    logic [10:0] bits;
    int total;
    bits  = {stp, p, d, 1'b0};
    total = 11 * per;
    if (len >= 0 && len < total) total = len;
    for (int c = 0; c < total; c++) begin
      din = bits[c / per] ^ (c == spike);
      cyc(1);
    end
    din = 1'b1;
  endtask

  task automatic ack();
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] spike_exp;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 16, 16, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 16, 16, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1,  8,  8, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 20, 20, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 16, 16, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h5A, 1'b0, 1'b1,  5,  8, 8'h5A, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; din = 1'b1; div = 16'd16; ready = 1'b0;
    cyc(3);
    chk("reset valid", 32'(valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset overrun", 32'(overrun), 0);
    chk("reset data_out", 32'(data_out), 0);
    chk("reset parity_err", 32'(parity_err), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    cyc(3);

    for (int i = 0; i < 6; i++) begin
      div = 16'(vecs[i].div_v);
      send_frame(vecs[i].d, vecs[i].p, vecs[i].stp, vecs[i].per, -1, -1);
      cyc(3);
      $display("vector %0d: data %0h div %0d", i, vecs[i].d, vecs[i].div_v);
      chk("vec valid", 32'(valid), 1);
      chk("vec data_out", 32'(data_out), 32'(vecs[i].exp_d));
      chk("vec parity_err", 32'(parity_err), 32'(vecs[i].exp_pe));
      chk("vec frame_err", 32'(frame_err), 32'(vecs[i].exp_fe));
      chk("vec busy", 32'(busy), 0);
      chk("vec odd valid", 32'(valid_o), 1);
      chk("vec odd data_out", 32'(data_out_o), 32'(vecs[i].exp_d));
      chk("vec odd parity_err", 32'(parity_err_o), 32'(vecs[i].exp_pe_odd));
      chk("vec odd frame_err", 32'(frame_err_o), 32'(vecs[i].exp_fe));
      cyc(5);
      chk("vec valid held", 32'(valid), 1);
      ack();
      chk("vec valid after ack", 32'(valid), 0);
      cyc(4);
    end

    // Glitch: 3-clock low pulse
    div = 16'd16;
    din = 1'b0;
    cyc(3);
    din = 1'b1;
    chk("glitch busy rises", 32'(busy), 1);
    cyc(9);
    chk("glitch busy back to 0", 32'(busy), 0);
    chk("glitch odd busy back to 0", 32'(busy_o), 0);
    cyc(20);
    chk("glitch no valid", 32'(valid), 0);

    // Break: line low for 20 bit times
    din = 1'b0;
    cyc(320);
    chk("break valid", 32'(valid), 1);
    chk("break data_out", 32'(data_out), 0);
    chk("break frame_err", 32'(frame_err), 1);
    chk("break parity_err", 32'(parity_err), 0);
    ack();
    cyc(100);
    chk("break no second frame", 32'(valid), 0);
    chk("break idle while low", 32'(busy), 0);
    din = 1'b1;
    cyc(40);
    chk("break no frame on release", 32'(valid), 0);

    // Overrun
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 16, -1, -1);
    send_frame(8'h22, 1'b0, 1'b1, 16, -1, -1);
    cyc(3);
    chk("overrun valid", 32'(valid), 1);
    chk("overrun data held", 32'(data_out), 32'h11);
    chk("overrun flag", 32'(overrun), 1);
    chk("overrun odd flag", 32'(overrun_o), 1);
    ack();
    chk("overrun valid cleared", 32'(valid), 0);
    chk("overrun flag cleared", 32'(overrun), 0);
    cyc(4);

    // Divisor change mid-frame is ignored
    div = 16'd16;
    fork
      send_frame(8'h96, 1'b0, 1'b1, 16, -1, -1);
      begin
        cyc(40);
        div = 16'd32;
      end
    join
    cyc(3);
    chk("divchg valid", 32'(valid), 1);
    chk("divchg data_out", 32'(data_out), 32'h96);
    chk("divchg parity_err", 32'(parity_err), 0);

    // Reset during data bit 4 with a word still pending
    div = 16'd16;
    send_frame(8'h3C, 1'b0, 1'b1, 16, -1, 90);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midreset valid", 32'(valid), 0);
    chk("midreset data_out", 32'(data_out), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset overrun", 32'(overrun), 0);
    chk("midreset frame_err", 32'(frame_err), 0);
    chk("midreset parity_err", 32'(parity_err), 0);
    div = 16'd32;
    cyc(4);
    send_frame(8'h3C, 1'b0, 1'b1, 32, -1, -1);
    cyc(3);
    chk("post-reset valid", 32'(valid), 1);
    chk("post-reset data_out", 32'(data_out), 32'h3C);
    chk("post-reset parity_err", 32'(parity_err), 0);
    chk("post-reset frame_err", 32'(frame_err), 0);
    ack();
    cyc(4);

    // One-clock spike at the sample point of data bit 2
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 8'h00;
`else
    spike_exp = 8'h04;
`endif
    div = 16'd16;
    send_frame(8'h00, 1'b0, 1'b1, 16, 56, -1);
    cyc(3);
    chk("spike valid", 32'(valid), 1);
    chk("spike data_out", 32'(data_out), 32'(spike_exp));
    ack();
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
